// File: rtl/sfifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_ctrl_pkg
//  Description : Shared types for the single-clock FIFO controller.
//                ostate_t encodes the output-stage state; its single bit is
//                the out_valid flag itself.
//  Revision    : 1.0  initial release
// ============================================================================
package sfifo_ctrl_pkg;

  // Output-stage state: bit value doubles as out_valid.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } ostate_t;

endpackage : sfifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifomem.sv
`default_nettype none
// ============================================================================
//  Module      : fifomem
//  Description : Dual-port FIFO storage array. Synchronous write on wclk,
//                asynchronous (combinational) read so the controller can
//                capture the head word into its output register on the same
//                edge that advances the read pointer.
//  Ports       : rdata  - word at raddr (combinational)
//                wdata  - write word
//                waddr  - write address
//                raddr  - read address
//                wclken - write enable
//                wfull  - write blocked when set
//                wclk   - write clock
//  Revision    : 1.0  initial release
// ============================================================================
module fifomem #(
  parameter int    DATASIZE = 32,
  parameter int    ADDRSIZE = 4,
  parameter string RAM_TYPE = "distributed"
) (
  output logic [DATASIZE-1:0] rdata,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic                wclken,
  input  logic                wfull,
  input  logic                wclk
);

  localparam int DEPTH = 1 << ADDRSIZE;

  // Array contents are never reset; the controller's pointers define which
  // entries are meaningful.
  generate
    if (RAM_TYPE == "block") begin : g_block
      (* ram_style = "block" *) logic [DATASIZE-1:0] r_mem [DEPTH];

      always_ff @(posedge wclk) begin
        if (wclken && !wfull) r_mem[waddr] <= wdata;
      end

      assign rdata = r_mem[raddr];
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [DATASIZE-1:0] r_mem [DEPTH];

      always_ff @(posedge wclk) begin
        if (wclken && !wfull) r_mem[waddr] <= wdata;
      end

      assign rdata = r_mem[raddr];
    end
  endgenerate

endmodule : fifomem
`default_nettype wire

// File: rtl/sfifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_ctrl
//  Description : Single-clock FIFO controller around one fifomem instance.
//                Ready/valid on both sides, registered output stage, binary
//                wrap pointers, occupancy count and synchronous flush.
//                Capacity is DEPTH words in memory plus one in the output
//                register.
//  Ports       : clk         - clock, rising edge
//                rst_n       - asynchronous active-low reset
//                flush       - synchronous clear, highest priority
//                in_data     - write word
//                in_valid    - producer offers in_data
//                in_ready    - controller accepts (from registers and flush)
//                out_data    - registered head word
//                out_valid   - out_data is valid
//                out_ready   - consumer takes the head word
//                count       - words held (memory + output stage)
//                almost_full - count >= AFULL_THRESH
//  Revision    : 1.0  initial release
// ============================================================================
module sfifo_ctrl
  import sfifo_ctrl_pkg::*;
#(
  parameter int    DATASIZE     = 32,
  parameter int    ADDRSIZE     = 4,
  parameter string RAM_TYPE     = "distributed",
  parameter int    AFULL_THRESH = (1 << ADDRSIZE) - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDRSIZE:0]   count,
  output logic                almost_full
);

  localparam int          PTRW    = ADDRSIZE + 1;
  localparam logic [31:0] C_AFULL = 32'(AFULL_THRESH);

  logic [PTRW-1:0]     r_wptr;
  logic [PTRW-1:0]     r_rptr;
  ostate_t             r_state;
  logic [DATASIZE-1:0] r_out_data;

  logic [PTRW-1:0]     w_mem_cnt;
  logic                w_mem_empty;
  logic                w_mem_full;
  logic                w_wclken;
  logic                w_pop;
  logic                w_load;
  logic [DATASIZE-1:0] w_rdata;

  // --------------------------------------------------------------------------
  // Pointer comparisons. The extra MSB distinguishes full from empty when the
  // address bits coincide.
  // --------------------------------------------------------------------------
  assign w_mem_cnt   = r_wptr - r_rptr;
  assign w_mem_empty = (r_wptr == r_rptr);
  assign w_mem_full  = (r_wptr[PTRW-1] != r_rptr[PTRW-1]) &&
                       (r_wptr[PTRW-2:0] == r_rptr[PTRW-2:0]);

  // in_ready never looks at in_valid, so no combinational loop can form
  // through a producer that waits for ready.
  assign in_ready  = !w_mem_full && !flush;
  assign w_wclken  = in_valid && in_ready;

  assign out_valid = (r_state == ST_VALID);
  assign out_data  = r_out_data;
  assign w_pop     = out_valid && out_ready;

  // The output register is (re)loaded whenever it is empty or being popped
  // and memory has a word; the read uses the pre-edge rptr, so a word written
  // this cycle is never visible until the following edge.
  assign w_load    = !w_mem_empty && ((r_state == ST_EMPTY) || w_pop);

  assign count       = w_mem_cnt + PTRW'(out_valid);
  assign almost_full = (32'(count) >= C_AFULL);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  fifomem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE),
    .RAM_TYPE (RAM_TYPE)
  ) u_fifomem (
    .rdata  (w_rdata),
    .wdata  (in_data),
    .waddr  (r_wptr[ADDRSIZE-1:0]),
    .raddr  (r_rptr[ADDRSIZE-1:0]),
    .wclken (w_wclken),
    .wfull  (w_mem_full),
    .wclk   (clk)
  );

  // --------------------------------------------------------------------------
  // Write pointer. Flush has priority; w_wclken is already 0 during flush.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
    end else if (w_wclken) begin
      r_wptr <= r_wptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage and read pointer. On a pop with memory empty the state
  // drops to EMPTY but out_data keeps its last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr     <= '0;
      r_state    <= ST_EMPTY;
      r_out_data <= '0;
    end else if (flush) begin
      r_rptr     <= '0;
      r_state    <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_out_data <= w_rdata;
            r_rptr     <= r_rptr + 1'b1;
            r_state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (w_load) begin
            r_out_data <= w_rdata;
            r_rptr     <= r_rptr + 1'b1;
          end else if (w_pop) begin
            r_state    <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule : sfifo_ctrl
`default_nettype wire

// File: tb/tb_sfifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfifo_ctrl
//  Description : Self-checking bench for sfifo_ctrl (ADDRSIZE=2, capacity 5,
//                AFULL_THRESH=4). Accepted words go into a reference queue;
//                each pop is compared against the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sfifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          almost_full;

  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_pop  = 0;
  logic [DW-1:0] q_exp [$];

  sfifo_ctrl #(
    .DATASIZE     (DW),
    .ADDRSIZE     (AW),
    .RAM_TYPE     ("distributed"),
    .AFULL_THRESH (4)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they are stable
  // and describe exactly what the next posedge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_exp.delete();
    end else begin
      chk("count", 32'(count), 32'(q_exp.size()));
      chk("afull", 32'(almost_full), 32'(q_exp.size() >= 4));
      if (flush) begin
        q_exp.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q_exp.size() == 0) begin
            chk("pop_unexpected", 32'(1), 32'(0));
          end else begin
            chk("data", 32'(out_data), 32'(q_exp.pop_front()));
            n_pop++;
          end
        end
        if (in_valid && in_ready) q_exp.push_back(in_data);
      end
    end
  end

  task automatic write_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    if (!in_ready) chk("wr_timeout", 32'(0), 32'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (count != 0); i++) tick();
    chk("drain_done", 32'(count), 32'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    int idx;
    int pop0;
    logic adv;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_afull", 32'(almost_full), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    rst_n = 1'b1;
    tick();

    // ---- Reset mid-stream ----
    write_word(8'h01);
    write_word(8'h02);
    write_word(8'h03);
    tick();
    chk("pre_rst_count", 32'(count), 32'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    in_valid = 1'b0;
    chk("a1_lat1_valid", 32'(out_valid), 32'(0));
    tick();
    chk("a1_lat2_valid", 32'(out_valid), 32'(1));
    chk("a1_lat2_data", 32'(out_data), 32'hA1);
    drain();

    // ---- Fill to capacity, then full with simultaneous pop/write ----
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h10 + i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_in_ready", 32'(in_ready), 32'(i < 4));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 4));
    end
    in_data = 8'h15;
    tick();
    chk("full_hold_count", 32'(count), 32'(5));
    chk("full_hold_ready", 32'(in_ready), 32'(0));
    tick();
    chk("full_hold_count2", 32'(count), 32'(5));
    out_ready = 1'b1;
    chk("simul_ready_pre", 32'(in_ready), 32'(0));
    tick();
    out_ready = 1'b0;
    chk("simul_count_4", 32'(count), 32'(4));
    chk("simul_ready_post", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    chk("simul_count_5", 32'(count), 32'(5));
    drain();

    // ---- Order and wrap: 20 words, consumer toggles ----
    pop0 = n_pop;
    idx  = 0;
    for (int cyc = 0; cyc < 300 && idx < 20; cyc++) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = 1'b1;
      in_data   = DW'(idx);
      adv       = in_ready;
      tick();
      if (adv) idx++;
    end
    in_valid = 1'b0;
    chk("wrap_sent", 32'(idx), 32'(20));
    drain();
    chk("wrap_pops", 32'(n_pop - pop0), 32'(20));

    // ---- Flush with concurrent write and pop ----
    write_word(8'h31);
    write_word(8'h32);
    write_word(8'h33);
    tick();
    tick();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("post_flush_lat1", 32'(out_valid), 32'(0));
    tick();
    chk("post_flush_lat2", 32'(out_valid), 32'(1));
    chk("post_flush_data", 32'(out_data), 32'h5A);
    drain();

    // ---- Single word drain: out_valid high exactly one cycle ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("one_c1_valid", 32'(out_valid), 32'(0));
    tick();
    chk("one_c2_valid", 32'(out_valid), 32'(1));
    chk("one_c2_data", 32'(out_data), 32'h77);
    tick();
    chk("one_c3_valid", 32'(out_valid), 32'(0));
    chk("one_c3_hold", 32'(out_data), 32'h77);
    tick();
    chk("one_c4_valid", 32'(out_valid), 32'(0));
    out_ready = 1'b0;

    tick();
    chk("scoreboard_empty", 32'(q_exp.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_sfifo_ctrl
`default_nettype wire
